// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the unified memory port arbiter.
// The master modport is the arbiter's view; the slave modport is the pipeline/memory view.
interface mem_port_arbiter_if #(
   parameter int ADDR_SIZE = 31,
   parameter int DATA_SIZE = 31
);
   logic                 if_req;
   logic [ADDR_SIZE:0]   if_addr;
   logic                 if_ack;
   logic [DATA_SIZE:0]   if_rdata;

   logic                 d_req;
   logic                 d_we;
   logic [ADDR_SIZE:0]   d_addr;
   logic [DATA_SIZE:0]   d_wdata;
   logic                 d_ack;
   logic [DATA_SIZE:0]   d_rdata;

   logic                 m_sel;
   logic                 m_en;
   logic                 m_we;
   logic [ADDR_SIZE:0]   m_addr;
   logic [DATA_SIZE:0]   m_wdata;
   logic                 m_ready;
   logic [DATA_SIZE:0]   m_rdata;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
      output if_ack, if_rdata, d_ack, d_rdata, m_sel, m_en, m_we, m_addr, m_wdata
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
      input  if_ack, if_rdata, d_ack, d_rdata, m_sel, m_en, m_we, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Each grant runs ISSUE (one-cycle strobe), WAIT (for m_ready), RESP (one-cycle ack).
module mem_port_arbiter #(
   parameter int ADDR_SIZE = 31,
   parameter int DATA_SIZE = 31
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic               r_rrLast;
   logic               r_sel;
   logic               r_we;
   logic [ADDR_SIZE:0] r_addr;
   logic [DATA_SIZE:0] r_wdata;
   logic [DATA_SIZE:0] r_ifRdata;
   logic [DATA_SIZE:0] r_dRdata;

   logic               w_ifElig;
   logic               w_dElig;
   logic               w_grant;
   logic               w_grantData;
   logic               w_done;

   // A port whose ack is high this cycle is not eligible, so a held req cannot be served twice.
   assign w_ifElig = bus.if_req && !bus.if_ack;
   assign w_dElig  = bus.d_req  && !bus.d_ack;
   assign w_done   = (r_state == ST_WAIT) && bus.m_ready;

   always_comb begin
      w_nextState = r_state;
      w_grant     = 1'b0;
      w_grantData = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ifElig || w_dElig) begin
               w_grant     = 1'b1;
               w_grantData = (w_ifElig && w_dElig) ? !r_rrLast : w_dElig;
               w_nextState = ST_ISSUE;
            end
         end
         ST_ISSUE: w_nextState = ST_WAIT;
         ST_WAIT: begin
            if (bus.m_ready) begin
               w_nextState = ST_RESP;
            end
         end
         ST_RESP:  w_nextState = ST_IDLE;
         default:  w_nextState = ST_IDLE;
      endcase
   end

   // r_rrLast: 0 = fetch was granted last, 1 = data was granted last.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_rrLast  <= 1'b0;
         r_sel     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_ifRdata <= '0;
         r_dRdata  <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_grant) begin
            r_sel    <= w_grantData;
            r_rrLast <= w_grantData;
            r_addr   <= w_grantData ? bus.d_addr : bus.if_addr;
            r_we     <= w_grantData && bus.d_we;
            if (w_grantData) begin
               r_wdata <= bus.d_wdata;
            end
         end
         if (w_done) begin
            r_we <= 1'b0;
            if (!r_we) begin
               if (r_sel) begin
                  r_dRdata <= bus.m_rdata;
               end else begin
                  r_ifRdata <= bus.m_rdata;
               end
            end
         end
      end
   end

   assign bus.m_en     = (r_state == ST_ISSUE);
   assign bus.if_ack   = (r_state == ST_RESP) && !r_sel;
   assign bus.d_ack    = (r_state == ST_RESP) &&  r_sel;
   assign bus.m_sel    = r_sel;
   assign bus.m_we     = r_we;
   assign bus.m_addr   = r_addr;
   assign bus.m_wdata  = r_wdata;
   assign bus.if_rdata = r_ifRdata;
   assign bus.d_rdata  = r_dRdata;

endmodule
